// File: rtl/out_port_ctrl_if.sv
// Write-bus / downstream-handshake bundle for out_port_ctrl_regs.
// Optional readback signals appear only when OUT_REGS_READBACK_EN is defined.
interface out_port_ctrl_if #(
  parameter int DATA_W   = 8,
  parameter int ID_W     = 8,
  parameter int NUM_REGS = 2
);
  logic                         write_strobe;
  logic [ID_W-1:0]              port_id;
  logic [DATA_W-1:0]            out_port;
  logic [NUM_REGS*DATA_W-1:0]   reg_bus;
  logic                         listo;
  logic                         req_wr;
  logic                         req_rd;
  logic                         ack;
  logic                         busy;
  logic                         done;
  logic                         err;
`ifdef OUT_REGS_READBACK_EN
  logic                         read_strobe;
  logic [DATA_W-1:0]            in_port;

  modport master (
    output write_strobe, port_id, out_port, ack, read_strobe,
    input  reg_bus, listo, req_wr, req_rd, busy, done, err, in_port
  );
  modport slave (
    input  write_strobe, port_id, out_port, ack, read_strobe,
    output reg_bus, listo, req_wr, req_rd, busy, done, err, in_port
  );
`else
  modport master (
    output write_strobe, port_id, out_port, ack,
    input  reg_bus, listo, req_wr, req_rd, busy, done, err
  );
  modport slave (
    input  write_strobe, port_id, out_port, ack,
    output reg_bus, listo, req_wr, req_rd, busy, done, err
  );
`endif
endinterface

// File: rtl/out_port_ctrl_regs.sv
// PicoBlaze output-port register file with a command register driving a req/ack FSM with timeout.
// Optional readback port (read_strobe/in_port) is built when OUT_REGS_READBACK_EN is defined.
module out_port_ctrl_regs #(
  parameter int              DATA_W   = 8,
  parameter int              ID_W     = 8,
  parameter int              NUM_REGS = 2,
  parameter logic [ID_W-1:0] BASE_ID  = ID_W'(4),
  parameter logic [ID_W-1:0] CTRL_ID  = ID_W'(1),
  parameter int              TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst,
  out_port_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [NUM_REGS*DATA_W-1:0] reg_q;
  logic                       listo_q, req_wr_q, req_rd_q, busy_q, done_q, err_q;

  logic [ID_W-1:0]  idx;
  logic             data_hit, ctrl_hit, cmd_wr, cmd_rd;
  logic             start_ok, err_set, err_clr, timeout_hit;
  logic [CNT_W-1:0] cnt_inc;

  // Address decode and command qualification
  assign idx         = bus.port_id - BASE_ID;
  assign data_hit    = bus.write_strobe && (bus.port_id >= BASE_ID) && (idx < ID_W'(NUM_REGS));
  assign ctrl_hit    = bus.write_strobe && (bus.port_id == CTRL_ID);
  assign cmd_wr      = bus.out_port[1];
  assign cmd_rd      = bus.out_port[2];
  assign start_ok    = ctrl_hit && (cmd_wr ^ cmd_rd) && (state_q == IDLE);
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (state_q == REQ) && !bus.ack && (cnt_inc == CNT_W'(TIMEOUT));
  assign err_clr     = ctrl_hit && bus.out_port[7];
  // A fault in the same write as a clear request leaves err set.
  assign err_set     = (data_hit && busy_q)
                     || (ctrl_hit && cmd_wr && cmd_rd)
                     || (ctrl_hit && (cmd_wr || cmd_rd) && busy_q)
                     || timeout_hit;

  // Data registers: frozen while a transaction is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q <= '0;
    end else if (data_hit && !busy_q) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (idx == ID_W'(k)) reg_q[k*DATA_W +: DATA_W] <= bus.out_port;
      end
    end
  end

  // Control register and transaction FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      listo_q  <= 1'b0;
      req_wr_q <= 1'b0;
      req_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (ctrl_hit) listo_q <= bus.out_port[0];
      err_q <= (err_q && !err_clr) || err_set;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q  <= REQ;
            req_wr_q <= cmd_wr;
            req_rd_q <= cmd_rd;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
          end
        end
        REQ: begin
          cnt_q <= cnt_inc;
          if (bus.ack || timeout_hit) begin
            req_wr_q <= 1'b0;
            req_rd_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.reg_bus = reg_q;
  assign bus.listo   = listo_q;
  assign bus.req_wr  = req_wr_q;
  assign bus.req_rd  = req_rd_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

`ifdef OUT_REGS_READBACK_EN
  logic [DATA_W-1:0] rd_mux, in_port_q;

  always_comb begin
    rd_mux = '0;
    if (bus.port_id == CTRL_ID) begin
      rd_mux[7] = err_q;
      rd_mux[6] = busy_q;
      rd_mux[0] = listo_q;
    end else if ((bus.port_id >= BASE_ID) && (idx < ID_W'(NUM_REGS))) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (idx == ID_W'(k)) rd_mux = reg_q[k*DATA_W +: DATA_W];
      end
    end
  end

  // Readback register: one-cycle latency, holds between reads
  always_ff @(posedge clk) begin
    if (rst)                  in_port_q <= '0;
    else if (bus.read_strobe) in_port_q <= rd_mux;
  end

  assign bus.in_port = in_port_q;
`endif

endmodule

// File: tb/tb_out_port_ctrl_regs.sv
// Directed self-checking bench for out_port_ctrl_regs (TIMEOUT=10, two data registers).
module tb_out_port_ctrl_regs;

  localparam int DATA_W   = 8;
  localparam int ID_W     = 8;
  localparam int NUM_REGS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;

  out_port_ctrl_if #(.DATA_W(DATA_W), .ID_W(ID_W), .NUM_REGS(NUM_REGS)) bus ();

  out_port_ctrl_regs #(
    .DATA_W(DATA_W), .ID_W(ID_W), .NUM_REGS(NUM_REGS),
    .BASE_ID(8'h04), .CTRL_ID(8'h01), .TIMEOUT(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.done) done_cnt++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    bus.write_strobe = 1'b1;
    bus.port_id      = id;
    bus.out_port     = data;
    tick();
    bus.write_strobe = 1'b0;
  endtask

  // {listo, req_wr, req_rd, busy, done, err}
  function automatic logic [31:0] flags();
    return 32'({bus.listo, bus.req_wr, bus.req_rd, bus.busy, bus.done, bus.err});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi;
    int d0;
    bus.write_strobe = 1'b0;
    bus.port_id      = '0;
    bus.out_port     = '0;
    bus.ack          = 1'b0;
`ifdef OUT_REGS_READBACK_EN
    bus.read_strobe  = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;

    // Reset state and data writes
    check_val("rst_reg_bus", 32'(bus.reg_bus), 32'h0);
    check_val("rst_flags",   flags(), 32'h0);
    wr(8'h04, 8'hA5);
    check_val("wr_reg0", 32'(bus.reg_bus), 32'h00A5);
    wr(8'h05, 8'h3C);
    check_val("wr_reg1", 32'(bus.reg_bus), 32'h3CA5);
    check_val("wr_flags", flags(), 32'h0);
    wr(8'h06, 8'h77);
    check_val("unmapped_id", 32'(bus.reg_bus), 32'h3CA5);
    check_val("unmapped_flags", flags(), 32'h0);

`ifdef OUT_REGS_READBACK_EN
    bus.read_strobe = 1'b1; bus.port_id = 8'h05;
    tick();
    bus.read_strobe = 1'b0;
    check_val("rb_reg1", 32'(bus.in_port), 32'h3C);
`endif

    // Write transaction, ack four cycles after the strobe
    d0 = done_cnt;
    wr(8'h01, 8'h03);
    check_val("t2_start", flags(), 32'b110100);
    for (int i = 0; i < 3; i++) begin
`ifdef OUT_REGS_READBACK_EN
      if (i == 0) begin bus.read_strobe = 1'b1; bus.port_id = 8'h01; end
`endif
      tick();
`ifdef OUT_REGS_READBACK_EN
      if (i == 0) begin
        bus.read_strobe = 1'b0;
        check_val("rb_ctrl_busy", 32'(bus.in_port), 32'h41);
      end
`endif
      check_val("t2_hold", flags(), 32'b110100);
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check_val("t2_done", flags(), 32'b100110);
    tick();
    check_val("t2_idle", flags(), 32'b100000);
    check_val("t2_done_once", 32'(done_cnt - d0), 32'd1);

    // Read transaction with no ack: timeout after 10 cycles
    d0 = done_cnt;
    wr(8'h01, 8'h04);
    check_val("t3_start", flags(), 32'b001100);
    hi = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!bus.req_rd) break;
      hi++;
    end
    check_val("t3_req_cycles", 32'(hi), 32'd10);
    check_val("t3_timeout", flags(), 32'b000111);
    tick();
    check_val("t3_idle_err", flags(), 32'b000001);
    check_val("t3_done_once", 32'(done_cnt - d0), 32'd1);
    wr(8'h01, 8'h80);
    check_val("t3_err_clr", flags(), 32'h0);

    // Ack coincident with the timeout cycle: ack wins
    wr(8'h01, 8'h04);
    for (int i = 0; i < 9; i++) tick();
    check_val("tie_still_req", flags(), 32'b001100);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check_val("tie_ack_wins", flags(), 32'b000110);
    tick();
    // Ack outside REQ is ignored
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    check_val("ack_in_idle", flags(), 32'h0);

    // Writes while busy are blocked and flag an error
    d0 = done_cnt;
    wr(8'h01, 8'h02);
    wr(8'h04, 8'hFF);
    check_val("t4_reg_frozen", 32'(bus.reg_bus), 32'h3CA5);
    check_val("t4_err_data", flags(), 32'b010101);
    wr(8'h01, 8'h02);
    check_val("t4_err_cmd", flags(), 32'b010101);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    tick();
    check_val("t4_no_second", flags(), 32'b000001);
    check_val("t4_done_once", 32'(done_cnt - d0), 32'd1);
    wr(8'h01, 8'h80);

    // Reset mid-transaction alongside a write strobe
    wr(8'h01, 8'h05);
    tick();
    d0 = done_cnt;
    rst = 1'b1;
    bus.write_strobe = 1'b1; bus.port_id = 8'h04; bus.out_port = 8'h55;
    tick();
    rst = 1'b0;
    bus.write_strobe = 1'b0;
    check_val("t5_rst_regs", 32'(bus.reg_bus), 32'h0);
    check_val("t5_rst_flags", flags(), 32'h0);
    tick(); tick();
    check_val("t5_no_done", 32'(done_cnt - d0), 32'd0);
    wr(8'h01, 8'h02);
    check_val("t5_idle_accept", flags(), 32'b010100);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    wr(8'h01, 8'h06);
    check_val("t5_both_bits", flags(), 32'b000001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
